// File: rtl/ps2_hack_keyboard_pkg.sv
// rtl/ps2_hack_keyboard_pkg.sv - Shared keycodes, scancodes and receiver states for ps2_hack_keyboard
package ps2_hack_keyboard_pkg;

   localparam logic [7:0] HACK_KEY_NEWLINE   = 8'd128;
   localparam logic [7:0] HACK_KEY_BACKSPACE = 8'd129;
   localparam logic [7:0] HACK_KEY_LEFT      = 8'd130;
   localparam logic [7:0] HACK_KEY_UP        = 8'd131;
   localparam logic [7:0] HACK_KEY_RIGHT     = 8'd132;
   localparam logic [7:0] HACK_KEY_DOWN      = 8'd133;
   localparam logic [7:0] HACK_KEY_HOME      = 8'd134;
   localparam logic [7:0] HACK_KEY_END       = 8'd135;
   localparam logic [7:0] HACK_KEY_PGUP      = 8'd136;
   localparam logic [7:0] HACK_KEY_PGDN      = 8'd137;
   localparam logic [7:0] HACK_KEY_INSERT    = 8'd138;
   localparam logic [7:0] HACK_KEY_DELETE    = 8'd139;
   localparam logic [7:0] HACK_KEY_ESC       = 8'd140;
   localparam logic [7:0] HACK_KEY_F1        = 8'd141;
   localparam logic [7:0] HACK_KEY_F2        = 8'd142;
   localparam logic [7:0] HACK_KEY_F3        = 8'd143;
   localparam logic [7:0] HACK_KEY_F4        = 8'd144;
   localparam logic [7:0] HACK_KEY_F5        = 8'd145;
   localparam logic [7:0] HACK_KEY_F6        = 8'd146;
   localparam logic [7:0] HACK_KEY_F7        = 8'd147;
   localparam logic [7:0] HACK_KEY_F8        = 8'd148;
   localparam logic [7:0] HACK_KEY_F9        = 8'd149;
   localparam logic [7:0] HACK_KEY_F10       = 8'd150;
   localparam logic [7:0] HACK_KEY_F11       = 8'd151;
   localparam logic [7:0] HACK_KEY_F12       = 8'd152;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/ps2_hack_keyboard_if.sv
// rtl/ps2_hack_keyboard_if.sv - PS/2 line inputs and Hack keycode outputs of ps2_hack_keyboard
interface ps2_hack_keyboard_if;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic [7:0] keycode;
   logic       key_event;
   logic       frame_error;

   modport slave  (input  ps2_clk_i, ps2_data_i, output keycode, key_event, frame_error);
   modport master (output ps2_clk_i, ps2_data_i, input  keycode, key_event, frame_error);
endinterface

// File: rtl/ps2_scancode_to_hack.sv
// rtl/ps2_scancode_to_hack.sv - Combinational set-2 {ext, code, shift} to Hack keycode lookup, 0 = unmapped
module ps2_scancode_to_hack
   import ps2_hack_keyboard_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] code,
   input  logic       shift,
   output logic [7:0] keycode
);

   always_comb begin
      keycode = 8'h00;
      case ({ext, code})
         // letters are always uppercase
         9'h01C: keycode = 8'h41;  9'h032: keycode = 8'h42;  9'h021: keycode = 8'h43;  9'h023: keycode = 8'h44;
         9'h024: keycode = 8'h45;  9'h02B: keycode = 8'h46;  9'h034: keycode = 8'h47;  9'h033: keycode = 8'h48;
         9'h043: keycode = 8'h49;  9'h03B: keycode = 8'h4A;  9'h042: keycode = 8'h4B;  9'h04B: keycode = 8'h4C;
         9'h03A: keycode = 8'h4D;  9'h031: keycode = 8'h4E;  9'h044: keycode = 8'h4F;  9'h04D: keycode = 8'h50;
         9'h015: keycode = 8'h51;  9'h02D: keycode = 8'h52;  9'h01B: keycode = 8'h53;  9'h02C: keycode = 8'h54;
         9'h03C: keycode = 8'h55;  9'h02A: keycode = 8'h56;  9'h01D: keycode = 8'h57;  9'h022: keycode = 8'h58;
         9'h035: keycode = 8'h59;  9'h01A: keycode = 8'h5A;
         9'h016: keycode = shift ? 8'h21 : 8'h31;
         9'h01E: keycode = shift ? 8'h40 : 8'h32;
         9'h026: keycode = shift ? 8'h23 : 8'h33;
         9'h025: keycode = shift ? 8'h24 : 8'h34;
         9'h02E: keycode = shift ? 8'h25 : 8'h35;
         9'h036: keycode = shift ? 8'h5E : 8'h36;
         9'h03D: keycode = shift ? 8'h26 : 8'h37;
         9'h03E: keycode = shift ? 8'h2A : 8'h38;
         9'h046: keycode = shift ? 8'h28 : 8'h39;
         9'h045: keycode = shift ? 8'h29 : 8'h30;
         9'h04E: keycode = shift ? 8'h5F : 8'h2D;
         9'h055: keycode = shift ? 8'h2B : 8'h3D;
         9'h054: keycode = shift ? 8'h7B : 8'h5B;
         9'h05B: keycode = shift ? 8'h7D : 8'h5D;
         9'h05D: keycode = shift ? 8'h7C : 8'h5C;
         9'h04C: keycode = shift ? 8'h3A : 8'h3B;
         9'h052: keycode = shift ? 8'h22 : 8'h27;
         9'h041: keycode = shift ? 8'h3C : 8'h2C;
         9'h049: keycode = shift ? 8'h3E : 8'h2E;
         9'h04A: keycode = shift ? 8'h3F : 8'h2F;
         9'h00E: keycode = shift ? 8'h7E : 8'h60;
         9'h029: keycode = 8'h20;
         9'h05A, 9'h15A: keycode = HACK_KEY_NEWLINE;
         9'h066: keycode = HACK_KEY_BACKSPACE;  9'h076: keycode = HACK_KEY_ESC;
         9'h16B: keycode = HACK_KEY_LEFT;    9'h175: keycode = HACK_KEY_UP;
         9'h174: keycode = HACK_KEY_RIGHT;   9'h172: keycode = HACK_KEY_DOWN;
         9'h16C: keycode = HACK_KEY_HOME;    9'h169: keycode = HACK_KEY_END;
         9'h17D: keycode = HACK_KEY_PGUP;    9'h17A: keycode = HACK_KEY_PGDN;
         9'h170: keycode = HACK_KEY_INSERT;  9'h171: keycode = HACK_KEY_DELETE;
         9'h005: keycode = HACK_KEY_F1;   9'h006: keycode = HACK_KEY_F2;   9'h004: keycode = HACK_KEY_F3;
         9'h00C: keycode = HACK_KEY_F4;   9'h003: keycode = HACK_KEY_F5;   9'h00B: keycode = HACK_KEY_F6;
         9'h083: keycode = HACK_KEY_F7;   9'h00A: keycode = HACK_KEY_F8;   9'h001: keycode = HACK_KEY_F9;
         9'h009: keycode = HACK_KEY_F10;  9'h078: keycode = HACK_KEY_F11;  9'h007: keycode = HACK_KEY_F12;
         default: keycode = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_hack_keyboard.sv
// rtl/ps2_hack_keyboard.sv - PS/2 set-2 receiver and Hack keycode decoder; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_hack_keyboard
   import ps2_hack_keyboard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int SYNC_STAGES    = 2
)(
   input  logic           clk,
   input  logic           reset,
   ps2_hack_keyboard_if.slave kb
);

   localparam logic [14:0] TIMEOUT_LIM = 15'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_prev, fall, ps2_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb.ps2_clk_i};
         data_sync <= {data_sync[SYNC_STAGES-2:0], kb.ps2_data_i};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
         fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      end
   end

   assign ps2_data = data_sync[SYNC_STAGES-1];

   rx_state_t   state, state_n;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg, rx_byte;
   logic [14:0] to_cnt;
   logic        par_err, timeout, byte_ok, rx_err, byte_valid, frame_error;

   assign timeout = (state != RX_IDLE) && !fall && (to_cnt == TIMEOUT_LIM);

   always_comb begin
      state_n = state;
      byte_ok = 1'b0;
      rx_err  = 1'b0;
      if (timeout) begin
         state_n = RX_IDLE;
         rx_err  = 1'b1;
      end else if (fall) begin
         case (state)
            RX_IDLE:   if (!ps2_data) state_n = RX_DATA; else rx_err = 1'b1;
            RX_DATA:   if (bit_cnt == 3'd7) state_n = RX_PARITY;
            RX_PARITY: state_n = RX_STOP;
            RX_STOP: begin
               state_n = RX_IDLE;
               if (ps2_data && !par_err) byte_ok = 1'b1;
               else                      rx_err  = 1'b1;
            end
            default:   state_n = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RX_IDLE;
         bit_cnt     <= 3'd0;
         shreg       <= 8'h00;
         rx_byte     <= 8'h00;
         to_cnt      <= 15'd0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_n;
         byte_valid  <= byte_ok;
         frame_error <= rx_err;
         to_cnt      <= (fall || state == RX_IDLE) ? 15'd0 : to_cnt + 15'd1;
         if (byte_ok) rx_byte <= shreg;
         if (state == RX_IDLE) bit_cnt <= 3'd0;
         if (fall && state == RX_DATA) begin
            shreg   <= {ps2_data, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   // data bits plus parity bit must hold an odd number of ones
   always_ff @(posedge clk) begin
      if (reset)                          par_err <= 1'b0;
      else if (fall && state == RX_PARITY) par_err <= ~^{shreg, ps2_data};
   end
`else
   assign par_err = 1'b0;
`endif

   logic       ext, brk, lshift, rshift, key_event, is_prefix, is_shift;
   logic [8:0] held;
   logic [7:0] keycode, keycode_n, lookup;

   ps2_scancode_to_hack u_map (
      .ext     (ext),
      .code    (rx_byte),
      .shift   (lshift | rshift),
      .keycode (lookup)
   );

   assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);
   assign is_shift  = !ext && ((rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT));

   always_comb begin
      keycode_n = keycode;
      if (byte_valid && !is_prefix && !is_shift) begin
         if (brk) begin
            if ({ext, rx_byte} == held) keycode_n = 8'h00;
         end else if (lookup != 8'h00) begin
            keycode_n = lookup;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         held      <= 9'h000;
         keycode   <= 8'h00;
         key_event <= 1'b0;
      end else begin
         keycode   <= keycode_n;
         key_event <= (keycode_n != keycode);
         if (byte_valid) begin
            if (rx_byte == SC_EXT)      ext <= 1'b1;
            else if (rx_byte == SC_BRK) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (is_shift) begin
                  if (rx_byte == SC_LSHIFT) lshift <= !brk;
                  else                      rshift <= !brk;
               end else if (!brk && lookup != 8'h00) begin
                  held <= {ext, rx_byte};
               end
            end
         end
      end
   end

   assign kb.keycode     = keycode;
   assign kb.key_event   = key_event;
   assign kb.frame_error = frame_error;

endmodule
